// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory
// and registers the returned word into the IF/ID register, with stall, redirect and halt.
module fetch_stage #(
    parameter int unsigned    AW        = 8,
    parameter int unsigned    DW        = 32,
    parameter logic [AW-1:0]  RESET_PC  = '0,
    parameter bit             HALT_EN   = 1'b1,
    parameter logic [DW-1:0]  HALT_WORD = DW'(32'h0000_000C)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rd,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic          if_valid,
    output logic          halted,
    output logic [15:0]   fetch_count
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   if_instr_q, if_instr_d;
    logic [AW-1:0]   if_pc_q, if_pc_d;
    logic            if_valid_q, if_valid_d;
    logic            halted_q, halted_d;
    logic [CW-1:0]   fetch_count_q, fetch_count_d;
    logic            halt_hit;

    assign halt_hit = HALT_EN && (imem_rd == HALT_WORD);

    // Next-state and IF/ID update; everything holds unless a branch below says otherwise.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_valid_d    = if_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            IDLE: begin
                if_valid_d = 1'b0;
                if (redirect) pc_d = redirect_addr;
                if (start)    state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d       = redirect_addr;
                    if_valid_d = 1'b0;
                end else if (halt_hit && !stall) begin
                    if_valid_d = 1'b0;
                    halted_d   = 1'b1;
                    state_d    = HALT;
                end else if (!stall) begin
                    if_instr_d = imem_rd;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + AW'(1);
                    if (fetch_count_q != {CW{1'b1}})
                        fetch_count_d = fetch_count_q + CW'(1);
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
                halted_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_valid_q    <= if_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for run/stall/redirect/wrap,
// then hand-written halt and mid-run-reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, start, stall, redirect;
    logic [7:0]  redirect_addr;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid, halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_addr];

    fetch_stage #(
        .AW(8), .DW(32), .RESET_PC(8'h00), .HALT_EN(1'b1), .HALT_WORD(32'h2020_0002)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .imem_rd(imem_rd),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    typedef struct {
        logic        rst, start, stall, redir;
        logic [7:0]  raddr;
        logic        ev;
        logic [7:0]  epc;
        logic [31:0] ei;
        logic        eh;
        logic [15:0] ec;
        logic [7:0]  ea;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic r, logic s, logic st, logic rd, logic [7:0] ra,
                                logic ev, logic [7:0] epc, logic [31:0] ei,
                                logic eh, logic [15:0] ec, logic [7:0] ea);
        vec_t v;
        v.rst = r; v.start = s; v.stall = st; v.redir = rd; v.raddr = ra;
        v.ev = ev; v.epc = epc; v.ei = ei; v.eh = eh; v.ec = ec; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock edge with the given inputs; outputs are sampled 1 time unit later.
    task automatic step(input logic r, input logic s, input logic st,
                        input logic rd, input logic [7:0] ra);
        rst = r; start = s; stall = st; redirect = rd; redirect_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic ev, input logic [7:0] epc,
                              input logic [31:0] ei, input logic eh,
                              input logic [15:0] ec, input logic [7:0] ea);
        check({tag, "_valid"},  32'(if_valid),    32'(ev));
        check({tag, "_if_pc"},  32'(if_pc),       32'(epc));
        check({tag, "_instr"},  if_instr,         ei);
        check({tag, "_halted"}, 32'(halted),      32'(eh));
        check({tag, "_count"},  32'(fetch_count), 32'(ec));
        check({tag, "_addr"},   32'(imem_addr),   32'(ea));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hE000_0000 | 32'(i);
        mem[0] = 32'h2001_0003;
        mem[1] = 32'h2002_0009;
        mem[2] = 32'h0022_1020;
        mem[5] = 32'h2020_0002;

        //          rst  st  stl rd  raddr   ev  epc    instr          h   cnt  addr
        tbl[0]  = mk(1, 0, 0, 0, 8'h00,  0, 8'h00, 32'h0,          0, 16'd0, 8'h00);
        tbl[1]  = mk(0, 0, 0, 0, 8'h00,  0, 8'h00, 32'h0,          0, 16'd0, 8'h00);
        tbl[2]  = mk(0, 1, 0, 0, 8'h00,  0, 8'h00, 32'h0,          0, 16'd0, 8'h00);
        tbl[3]  = mk(0, 0, 0, 0, 8'h00,  1, 8'h00, 32'h2001_0003,  0, 16'd1, 8'h01);
        tbl[4]  = mk(0, 0, 0, 0, 8'h00,  1, 8'h01, 32'h2002_0009,  0, 16'd2, 8'h02);
        tbl[5]  = mk(0, 0, 1, 0, 8'h00,  1, 8'h01, 32'h2002_0009,  0, 16'd2, 8'h02);
        tbl[6]  = mk(0, 0, 1, 0, 8'h00,  1, 8'h01, 32'h2002_0009,  0, 16'd2, 8'h02);
        tbl[7]  = mk(0, 0, 1, 0, 8'h00,  1, 8'h01, 32'h2002_0009,  0, 16'd2, 8'h02);
        tbl[8]  = mk(0, 0, 0, 0, 8'h00,  1, 8'h02, 32'h0022_1020,  0, 16'd3, 8'h03);
        tbl[9]  = mk(0, 0, 0, 0, 8'h00,  1, 8'h03, 32'hE000_0003,  0, 16'd4, 8'h04);
        tbl[10] = mk(0, 0, 0, 0, 8'h00,  1, 8'h04, 32'hE000_0004,  0, 16'd5, 8'h05);
        tbl[11] = mk(0, 0, 1, 1, 8'h02,  0, 8'h04, 32'hE000_0004,  0, 16'd5, 8'h02);
        tbl[12] = mk(0, 0, 0, 0, 8'h00,  1, 8'h02, 32'h0022_1020,  0, 16'd6, 8'h03);
        tbl[13] = mk(0, 0, 0, 1, 8'hFF,  0, 8'h02, 32'h0022_1020,  0, 16'd6, 8'hFF);
        tbl[14] = mk(0, 0, 0, 0, 8'h00,  1, 8'hFF, 32'hE000_00FF,  0, 16'd7, 8'h00);
        tbl[15] = mk(0, 0, 0, 0, 8'h00,  1, 8'h00, 32'h2001_0003,  0, 16'd8, 8'h01);

        rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].stall, tbl[i].redir, tbl[i].raddr);
            expect_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei,
                       tbl[i].eh, tbl[i].ec, tbl[i].ea);
        end

        // Halt: five words delivered, a stalled halt word is not taken, then HALT is sticky.
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'h00);
        expect_all("pre_halt", 1, 8'h04, 32'hE000_0004, 0, 16'd5, 8'h05);
        step(0, 0, 1, 0, 8'h00);
        expect_all("halt_stalled", 1, 8'h04, 32'hE000_0004, 0, 16'd5, 8'h05);
        step(0, 0, 0, 0, 8'h00);
        expect_all("halt_enter", 0, 8'h04, 32'hE000_0004, 1, 16'd5, 8'h05);
        step(0, 1, 0, 0, 8'h00);
        expect_all("halt_start", 0, 8'h04, 32'hE000_0004, 1, 16'd5, 8'h05);
        step(0, 0, 0, 1, 8'h10);
        expect_all("halt_redir", 0, 8'h04, 32'hE000_0004, 1, 16'd5, 8'h05);
        step(0, 0, 0, 0, 8'h00);
        expect_all("halt_hold", 0, 8'h04, 32'hE000_0004, 1, 16'd5, 8'h05);

        // Reset mid-run while stalled, then idle until start; redirect in IDLE moves pc only.
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00);
        expect_all("pre_rst", 1, 8'h02, 32'h0022_1020, 0, 16'd3, 8'h03);
        step(1, 0, 1, 0, 8'h00);
        expect_all("mid_rst", 0, 8'h00, 32'h0, 0, 16'd0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 8'h00);
            expect_all($sformatf("post_rst%0d", i), 0, 8'h00, 32'h0, 0, 16'd0, 8'h00);
        end
        step(0, 0, 0, 1, 8'h01);
        expect_all("idle_redir", 0, 8'h00, 32'h0, 0, 16'd0, 8'h01);
        step(0, 1, 0, 0, 8'h00);
        expect_all("restart", 0, 8'h00, 32'h0, 0, 16'd0, 8'h01);
        step(0, 0, 0, 0, 8'h00);
        expect_all("restart_fetch", 1, 8'h01, 32'h2002_0009, 0, 16'd1, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
